// File: rtl/add_pipe_n.sv
// add_pipe_n: pipelined add/sub on the upper DATA_W-TRUNC_W bits of each operand, LATENCY cycles deep.
// Define ADD_PIPE_SAT_EN to saturate the field on overflow instead of wrapping.
module add_pipe_n #(
  parameter int DATA_W  = 12,
  parameter int TRUNC_W = 4,
  parameter int LATENCY = 5,
  parameter int SIGNED  = 0
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              en_i,
  input  logic              valid_i,
  input  logic              sub_i,
  input  logic [DATA_W-1:0] data_1_i,
  input  logic [DATA_W-1:0] data_2_i,
  output logic [DATA_W-1:0] data_sum_o,
  output logic              valid_o,
  output logic              ovf_o
);

  localparam int U = DATA_W - TRUNC_W;

  logic [U-1:0]      a;
  logic [U-1:0]      b;
  logic [U:0]        a_ext;
  logic [U:0]        b_ext;
  logic [U:0]        r;
  logic              ovf;
  logic [U-1:0]      field;
  logic [DATA_W-1:0] word;

  always_comb begin
    a     = data_1_i[DATA_W-1:TRUNC_W];
    b     = data_2_i[DATA_W-1:TRUNC_W];
    a_ext = (SIGNED != 0) ? {a[U-1], a} : {1'b0, a};
    b_ext = (SIGNED != 0) ? {b[U-1], b} : {1'b0, b};
    r     = sub_i ? (a_ext - b_ext) : (a_ext + b_ext);
    // unsigned: r[U] is the carry on add and the borrow on sub
    ovf   = (SIGNED != 0) ? (r[U] != r[U-1]) : r[U];
`ifdef ADD_PIPE_SAT_EN
    if (ovf) begin
      if (SIGNED != 0) begin
        // r[U] holds the true sign: clamp toward it
        field      = {U{~r[U]}};
        field[U-1] = r[U];
      end else begin
        field = {U{~sub_i}};
      end
    end else begin
      field = r[U-1:0];
    end
`else
    field = r[U-1:0];
`endif
    word                   = '0;
    word[DATA_W-1:TRUNC_W] = field;
  end

  logic [DATA_W-1:0]  data_q [LATENCY];
  logic [LATENCY-1:0] valid_q;
  logic [LATENCY-1:0] ovf_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < LATENCY; i++) data_q[i] <= '0;
      valid_q <= '0;
      ovf_q   <= '0;
    end else if (en_i) begin
      data_q[0] <= word;
      for (int i = 1; i < LATENCY; i++) data_q[i] <= data_q[i-1];
      valid_q <= {valid_q[LATENCY-2:0], valid_i};
      ovf_q   <= {ovf_q[LATENCY-2:0], ovf};
    end
  end

  assign data_sum_o = data_q[LATENCY-1];
  assign valid_o    = valid_q[LATENCY-1];
  assign ovf_o      = ovf_q[LATENCY-1];

  generate
    if (TRUNC_W > 0) begin : g_trunc
      logic unused_low_bits;
      assign unused_low_bits = ^{data_1_i[TRUNC_W-1:0], data_2_i[TRUNC_W-1:0]};
    end
  endgenerate

endmodule

// File: tb/tb_add_pipe_n.sv
// tb_add_pipe_n: drives an unsigned and a signed add_pipe_n in parallel and checks both
// against an integer-arithmetic model indexed by enabled-edge count since reset.
module tb_add_pipe_n;
  localparam int DW   = 12;
  localparam int TW   = 4;
  localparam int LAT  = 5;
  localparam int U    = DW - TW;
  localparam int HSZ  = 4096;

  logic          clk = 0;
  logic          rst_n = 0;
  logic          en = 0;
  logic          valid = 0;
  logic          sub = 0;
  logic [DW-1:0] d1 = '0;
  logic [DW-1:0] d2 = '0;
  logic [DW-1:0] u_sum, s_sum;
  logic          u_v, u_o, s_v, s_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  add_pipe_n #(.DATA_W(DW), .TRUNC_W(TW), .LATENCY(LAT), .SIGNED(0)) dut_u (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .valid_i(valid), .sub_i(sub),
    .data_1_i(d1), .data_2_i(d2), .data_sum_o(u_sum), .valid_o(u_v), .ovf_o(u_o));

  add_pipe_n #(.DATA_W(DW), .TRUNC_W(TW), .LATENCY(LAT), .SIGNED(1)) dut_s (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .valid_i(valid), .sub_i(sub),
    .data_1_i(d1), .data_2_i(d2), .data_sum_o(s_sum), .valid_o(s_v), .ovf_o(s_o));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Returns {ovf, word}: range check on true integers, then clamp or wrap.
  function automatic logic [DW:0] ref_op(input bit sgn, input logic [DW-1:0] x,
                                         input logic [DW-1:0] y, input bit s);
    int a, b, r, lo, hi, f;
    bit ov;
    a = int'(x >> TW);
    b = int'(y >> TW);
    if (sgn) begin
      if (a >= (1 << (U-1))) a -= (1 << U);
      if (b >= (1 << (U-1))) b -= (1 << U);
      lo = -(1 << (U-1));
      hi = (1 << (U-1)) - 1;
    end else begin
      lo = 0;
      hi = (1 << U) - 1;
    end
    r  = s ? a - b : a + b;
    ov = (r < lo) || (r > hi);
`ifdef ADD_PIPE_SAT_EN
    if (r < lo) r = lo;
    else if (r > hi) r = hi;
`endif
    f = r & ((1 << U) - 1);
    return {ov, DW'(f << TW)};
  endfunction

  // model: history of inputs taken at each enabled edge since the last reset
  int            m = 0;
  bit            live = 0;
  bit            hv [HSZ];
  logic [DW:0]   hu [HSZ];
  logic [DW:0]   hs [HSZ];

  always @(posedge clk) begin
    if (!rst_n) begin
      m    = 0;
      live = 1;
    end else if (en) begin
      m++;
      hv[m % HSZ] = valid;
      hu[m % HSZ] = ref_op(0, d1, d2, sub);
      hs[m % HSZ] = ref_op(1, d1, d2, sub);
    end
  end

  always @(negedge clk) begin
    int j;
    if (live) begin
      j = m - LAT + 1;
      if (j < 1) begin
        chk("u_valid_empty", {31'b0, u_v}, 0);
        chk("s_valid_empty", {31'b0, s_v}, 0);
        chk("u_data_empty", {20'b0, u_sum}, 0);
        chk("s_data_empty", {20'b0, s_sum}, 0);
        chk("u_ovf_empty", {31'b0, u_o}, 0);
        chk("s_ovf_empty", {31'b0, s_o}, 0);
      end else begin
        chk("u_valid", {31'b0, u_v}, {31'b0, hv[j % HSZ]});
        chk("s_valid", {31'b0, s_v}, {31'b0, hv[j % HSZ]});
        if (hv[j % HSZ]) begin
          chk("u_data", {20'b0, u_sum}, {20'b0, hu[j % HSZ][DW-1:0]});
          chk("u_ovf", {31'b0, u_o}, {31'b0, hu[j % HSZ][DW]});
          chk("s_data", {20'b0, s_sum}, {20'b0, hs[j % HSZ][DW-1:0]});
          chk("s_ovf", {31'b0, s_o}, {31'b0, hs[j % HSZ][DW]});
        end
      end
    end
  end

  // One cycle: drive just after the rising edge, return at the falling edge.
  task automatic cyc(input bit r, input bit e, input bit v, input bit s,
                     input logic [DW-1:0] a, input logic [DW-1:0] b);
    @(posedge clk);
    #1;
    rst_n = r; en = e; valid = v; sub = s; d1 = a; d2 = b;
    @(negedge clk);
  endtask

  // Single op at cycle 0, then idle; capture first valid of each DUT.
  task automatic run_op(input logic [DW-1:0] a, input logic [DW-1:0] b, input bit s,
                        output logic [DW-1:0] ud, output bit uo,
                        output logic [DW-1:0] sd, output bit so,
                        output int at, output int nvalid);
    at = -1; nvalid = 0; ud = '0; uo = 0; sd = '0; so = 0;
    for (int c = 0; c < 10; c++) begin
      if (c == 0) cyc(1, 1, 1, s, a, b);
      else        cyc(1, 1, 0, 0, '0, '0);
      if (u_v) begin
        nvalid++;
        if (at < 0) begin
          at = c; ud = u_sum; uo = u_o; sd = s_sum; so = s_o;
        end
      end
    end
  endtask

  logic [DW-1:0] ud, sd;
  bit            uo, so;
  int            at, nv;
  int            seen [$];
  logic [DW-1:0] outs [$];
  bit            prev_en;

  initial begin
    cyc(0, 1, 0, 0, '0, '0);
    cyc(0, 1, 0, 0, '0, '0);
    chk("reset_valid", {31'b0, u_v}, 0);
    chk("reset_data", {20'b0, u_sum}, 0);

    // basic add, latency and single pulse
    run_op(12'h123, 12'h045, 0, ud, uo, sd, so, at, nv);
    chk("basic_latency", at, 5);
    chk("basic_pulses", nv, 1);
    chk("basic_data", {20'b0, ud}, 32'h160);
    chk("basic_ovf", {31'b0, uo}, 0);

    run_op(12'hF00, 12'h200, 0, ud, uo, sd, so, at, nv);
    chk("uadd_ovf", {31'b0, uo}, 1);
`ifdef ADD_PIPE_SAT_EN
    chk("uadd_sat", {20'b0, ud}, 32'hFF0);
`else
    chk("uadd_wrap", {20'b0, ud}, 32'h100);
`endif
    run_op(12'h100, 12'h200, 1, ud, uo, sd, so, at, nv);
    chk("usub_ovf", {31'b0, uo}, 1);
`ifdef ADD_PIPE_SAT_EN
    chk("usub_sat", {20'b0, ud}, 32'h000);
`else
    chk("usub_wrap", {20'b0, ud}, 32'hF00);
`endif
    run_op(12'h700, 12'h200, 0, ud, uo, sd, so, at, nv);
    chk("sadd_ovf", {31'b0, so}, 1);
`ifdef ADD_PIPE_SAT_EN
    chk("sadd_sat", {20'b0, sd}, 32'h7F0);
`else
    chk("sadd_wrap", {20'b0, sd}, 32'h900);
`endif
    run_op(12'h800, 12'h100, 1, ud, uo, sd, so, at, nv);
    chk("ssub_ovf", {31'b0, so}, 1);
`ifdef ADD_PIPE_SAT_EN
    chk("ssub_sat", {20'b0, sd}, 32'h800);
`else
    chk("ssub_wrap", {20'b0, sd}, 32'h700);
`endif

    // 8 back-to-back adds
    outs.delete();
    for (int c = 0; c < 16; c++) begin
      if (c < 8) cyc(1, 1, 1, 0, DW'(c * 16), 12'h010);
      else       cyc(1, 1, 0, 0, '0, '0);
      if (u_v) outs.push_back(u_sum);
    end
    chk("b2b_count", outs.size(), 8);
    for (int i = 0; i < 8 && i < outs.size(); i++)
      chk("b2b_data", {20'b0, outs[i]}, (i + 1) * 16);

    // stall after the first result emerges
    seen.delete();
    outs.delete();
    prev_en = 1;
    for (int c = 0; c < 16; c++) begin
      if (c < 4)                 cyc(1, 1, 1, 0, DW'(c * 32), 12'h050);
      else if (c >= 5 && c <= 7) cyc(1, 0, 1, 1, 12'hABC, 12'h123);
      else                       cyc(1, 1, 0, 0, '0, '0);
      if (u_v && prev_en) begin
        seen.push_back(c);
        outs.push_back(u_sum);
      end
      prev_en = en;
    end
    chk("stall_count", seen.size(), 4);
    if (seen.size() == 4) begin
      chk("stall_t0", seen[0], 5);
      chk("stall_t1", seen[1], 9);
      chk("stall_t2", seen[2], 10);
      chk("stall_t3", seen[3], 11);
      for (int i = 0; i < 4; i++) chk("stall_data", {20'b0, outs[i]}, i * 32 + 16 * 5);
    end

    // reset with ops in flight
    cyc(1, 1, 1, 0, 12'h110, 12'h220);
    cyc(1, 1, 1, 0, 12'h330, 12'h440);
    cyc(1, 1, 1, 0, 12'h550, 12'h660);
    cyc(0, 1, 1, 0, 12'h770, 12'h010);
    seen.delete();
    for (int c = 0; c < 10; c++) begin
      if (c == 0) begin
        cyc(1, 1, 1, 0, 12'h040, 12'h030);
        chk("rst_mid_valid", {31'b0, u_v}, 0);
        chk("rst_mid_data", {20'b0, u_sum}, 0);
        chk("rst_mid_ovf", {31'b0, u_o}, 0);
      end else begin
        cyc(1, 1, 0, 0, '0, '0);
      end
      if (u_v) seen.push_back(c);
    end
    chk("rst_new_count", seen.size(), 1);
    if (seen.size() > 0) chk("rst_new_time", seen[0], 5);

    // randomized traffic with stalls and occasional reset
    for (int c = 0; c < 3000; c++) begin
      logic [DW-1:0] a, b;
      case ($urandom_range(0, 5))
        0: a = 12'h000;
        1: a = 12'hFFF;
        2: a = 12'h800;
        3: a = 12'h7FF;
        default: a = DW'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0: b = 12'h000;
        1: b = 12'hFFF;
        2: b = 12'h800;
        3: b = 12'h7F0;
        default: b = DW'($urandom);
      endcase
      cyc($urandom_range(0, 199) != 0, $urandom_range(0, 7) != 0,
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, b);
    end
    for (int c = 0; c < 8; c++) cyc(1, 1, 0, 0, '0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
